// File: rtl/tl_ul_pkg.sv
// TileLink-UL channel beat layouts, field widths and opcode constants.
// Shared by the port buffer, its FIFO and anything talking to it.
package tl_ul_pkg;

    localparam int TL_OPW      = 3;
    localparam int TL_A_PARAMW = 3;
    localparam int TL_D_PARAMW = 2;
    localparam int TL_SZW      = 3;
    localparam int TL_SRCW     = 7;
    localparam int TL_AW       = 25;
    localparam int TL_DW       = 32;
    localparam int TL_MASKW    = TL_DW / 8;

    localparam logic [TL_OPW-1:0] OP_A_PUT_FULL    = 3'd0;
    localparam logic [TL_OPW-1:0] OP_A_PUT_PARTIAL = 3'd1;
    localparam logic [TL_OPW-1:0] OP_A_ARITHMETIC  = 3'd2;
    localparam logic [TL_OPW-1:0] OP_A_LOGICAL     = 3'd3;
    localparam logic [TL_OPW-1:0] OP_A_GET         = 3'd4;
    localparam logic [TL_OPW-1:0] OP_A_INTENT      = 3'd5;

    localparam logic [TL_OPW-1:0] OP_D_ACCESS_ACK      = 3'd0;
    localparam logic [TL_OPW-1:0] OP_D_ACCESS_ACK_DATA = 3'd1;
    localparam logic [TL_OPW-1:0] OP_D_HINT_ACK        = 3'd2;

    typedef struct packed {
        logic [TL_OPW-1:0]      opcode;
        logic [TL_A_PARAMW-1:0] param;
        logic [TL_SZW-1:0]      size;
        logic [TL_SRCW-1:0]     source;
        logic [TL_AW-1:0]       address;
        logic [TL_MASKW-1:0]    mask;
        logic [TL_DW-1:0]       data;
        logic                   corrupt;
    } tl_a_t;

    typedef struct packed {
        logic [TL_OPW-1:0]      opcode;
        logic [TL_D_PARAMW-1:0] param;
        logic [TL_SZW-1:0]      size;
        logic [TL_SRCW-1:0]     source;
        logic [TL_DW-1:0]       data;
        logic                   denied;
        logic                   corrupt;
    } tl_d_t;

    localparam int TL_A_W = $bits(tl_a_t);
    localparam int TL_D_W = $bits(tl_d_t);

    // A-channel opcodes that carry a data payload.
    function automatic logic a_has_data(input logic [TL_OPW-1:0] op);
        return (op == OP_A_PUT_FULL) || (op == OP_A_PUT_PARTIAL) ||
               (op == OP_A_ARITHMETIC) || (op == OP_A_LOGICAL);
    endfunction

endpackage

// File: rtl/tl_ul_fifo.sv
// Count/pointer FIFO, 1-cycle in-to-out latency, no bypass; in_rdy is low when full
// (even if the head pops that cycle) and until the first edge after reset.
module tl_ul_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] in_dat,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_dat
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             live_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push, pop;

    // live_q holds ready low through reset and releases it on the first edge after.
    assign in_rdy  = live_q & (count_q != FULL_C);
    assign out_vld = (count_q != '0);
    assign out_dat = mem_q[rd_ptr_q];

    assign push = in_vld & in_rdy;
    assign pop  = out_vld & out_rdy;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            live_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            live_q   <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_dat;
        end
    end

endmodule

// File: rtl/tl_ul_port_buffer.sv
// TL-UL A/D port buffer: one FIFO per channel, 1-cycle latency, plus an outstanding-request limiter.
// A accepts only while the A FIFO has room and inflight < MAX_INFLIGHT; D accepts while its FIFO has room.
module tl_ul_port_buffer
    import tl_ul_pkg::*;
#(
    parameter int A_DEPTH      = 2,
    parameter int D_DEPTH      = 2,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        a_in_valid,
    output logic        a_in_ready,
    input  tl_a_t       a_in_bits,
    output logic        a_out_valid,
    input  logic        a_out_ready,
    output tl_a_t       a_out_bits,
    input  logic        d_in_valid,
    output logic        d_in_ready,
    input  tl_d_t       d_in_bits,
    output logic        d_out_valid,
    input  logic        d_out_ready,
    output tl_d_t       d_out_bits,
    output logic [3:0]  inflight,
    output logic        err_unexpected_d
);

    localparam logic [3:0] MAX_IF = 4'(MAX_INFLIGHT);

    logic [3:0] inflight_q, inflight_d;
    logic       err_q, err_d;
    logic       inflight_ok;
    logic       a_fifo_in_rdy, d_fifo_in_rdy;
    logic       a_in_fire, d_in_fire, d_out_fire;

    assign inflight_ok = (inflight_q < MAX_IF);
    assign a_in_ready  = a_fifo_in_rdy & inflight_ok;
    assign d_in_ready  = d_fifo_in_rdy;

    assign a_in_fire  = a_in_valid & a_in_ready;
    assign d_in_fire  = d_in_valid & d_in_ready;
    assign d_out_fire = d_out_valid & d_out_ready;

    tl_ul_fifo #(
        .WIDTH (TL_A_W),
        .DEPTH (A_DEPTH)
    ) u_a_fifo (
        .clock   (clock),
        .reset   (reset),
        .in_vld  (a_in_valid & inflight_ok),
        .in_rdy  (a_fifo_in_rdy),
        .in_dat  (a_in_bits),
        .out_vld (a_out_valid),
        .out_rdy (a_out_ready),
        .out_dat (a_out_bits)
    );

    tl_ul_fifo #(
        .WIDTH (TL_D_W),
        .DEPTH (D_DEPTH)
    ) u_d_fifo (
        .clock   (clock),
        .reset   (reset),
        .in_vld  (d_in_valid),
        .in_rdy  (d_fifo_in_rdy),
        .in_dat  (d_in_bits),
        .out_vld (d_out_valid),
        .out_rdy (d_out_ready),
        .out_dat (d_out_bits)
    );

    // Responses delivered with nothing outstanding saturate at zero rather than wrap.
    always_comb begin
        inflight_d = inflight_q;
        err_d      = err_q | (d_in_fire & (inflight_q == 4'd0));
        unique case ({a_in_fire, d_out_fire})
            2'b10:   inflight_d = inflight_q + 4'd1;
            2'b01:   inflight_d = (inflight_q != 4'd0) ? inflight_q - 4'd1 : 4'd0;
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            inflight_q <= 4'd0;
            err_q      <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

    assign inflight         = inflight_q;
    assign err_unexpected_d = err_q;

    a_inflight_bound: assert property (@(posedge clock) disable iff (reset) inflight_q <= MAX_IF);

endmodule

// File: tb/tb_tl_ul_port_buffer.sv
// Bench for tl_ul_port_buffer: directed scenarios plus random traffic against a queue-based model.
module tb_tl_ul_port_buffer;
    import tl_ul_pkg::*;

    localparam int A_DEPTH      = 2;
    localparam int D_DEPTH      = 2;
    localparam int MAX_INFLIGHT = 4;

    logic       clock, reset;
    logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic       d_in_valid, d_in_ready, d_out_valid, d_out_ready;
    tl_a_t      a_in_bits, a_out_bits;
    tl_d_t      d_in_bits, d_out_bits;
    logic [3:0] inflight;
    logic       err_unexpected_d;

    tl_ul_port_buffer #(
        .A_DEPTH      (A_DEPTH),
        .D_DEPTH      (D_DEPTH),
        .MAX_INFLIGHT (MAX_INFLIGHT)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .a_in_valid       (a_in_valid),
        .a_in_ready       (a_in_ready),
        .a_in_bits        (a_in_bits),
        .a_out_valid      (a_out_valid),
        .a_out_ready      (a_out_ready),
        .a_out_bits       (a_out_bits),
        .d_in_valid       (d_in_valid),
        .d_in_ready       (d_in_ready),
        .d_in_bits        (d_in_bits),
        .d_out_valid      (d_out_valid),
        .d_out_ready      (d_out_ready),
        .d_out_bits       (d_out_bits),
        .inflight         (inflight),
        .err_unexpected_d (err_unexpected_d)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_chk = 0;
    int n_bad = 0;

    // Reference model: plain queues and a counter, advanced once per clock.
    tl_a_t aq[$];
    tl_d_t dq[$];
    int    infl;
    bit    err;
    bit    live;

    tl_a_t za;
    tl_d_t zd;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    function automatic tl_a_t mk_a(input logic [24:0] addr, input logic [6:0] src, input logic [31:0] dat);
        tl_a_t b;
        b         = '0;
        b.opcode  = OP_A_PUT_FULL;
        b.size    = 3'd2;
        b.source  = src;
        b.address = addr;
        b.mask    = 4'hf;
        b.data    = dat;
        return b;
    endfunction

    function automatic tl_d_t mk_d(input logic [6:0] src, input logic [31:0] dat);
        tl_d_t b;
        b        = '0;
        b.opcode = OP_D_ACCESS_ACK_DATA;
        b.size   = 3'd2;
        b.source = src;
        b.data   = dat;
        return b;
    endfunction

    task automatic model_clear();
        aq.delete();
        dq.delete();
        infl = 0;
        err  = 1'b0;
        live = 1'b0;
    endtask

    task automatic drive_idle();
        a_in_valid  = 1'b0;
        a_in_bits   = '0;
        a_out_ready = 1'b0;
        d_in_valid  = 1'b0;
        d_in_bits   = '0;
        d_out_ready = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_a_in_ready"},  128'(a_in_ready),  128'(0));
        check({tag, "_a_out_valid"}, 128'(a_out_valid), 128'(0));
        check({tag, "_d_in_ready"},  128'(d_in_ready),  128'(0));
        check({tag, "_d_out_valid"}, 128'(d_out_valid), 128'(0));
        check({tag, "_inflight"},    128'(inflight),    128'(0));
        check({tag, "_err"},         128'(err_unexpected_d), 128'(0));
    endtask

    // Entered and left on a falling edge; reset is released at the end.
    task automatic hold_reset();
        reset = 1'b1;
        drive_idle();
        model_clear();
        @(negedge clock);
        check_quiet("rst");
        @(negedge clock);
        reset = 1'b0;
    endtask

    // One clock: drive, compare every output to the model, then advance the model.
    task automatic step(input logic av, input tl_a_t ab, input logic aor,
                        input logic dv, input tl_d_t db, input logic dor);
        bit e_air, e_dir, ai, ao, di, dout;
        e_air = live && (aq.size() < A_DEPTH) && (infl < MAX_INFLIGHT);
        e_dir = live && (dq.size() < D_DEPTH);
        a_in_valid  = av;
        a_in_bits   = ab;
        a_out_ready = aor;
        d_in_valid  = dv;
        d_in_bits   = db;
        d_out_ready = dor;
        #1;
        check("a_in_ready",  128'(a_in_ready),  128'(e_air));
        check("a_out_valid", 128'(a_out_valid), 128'(aq.size() != 0));
        if (aq.size() != 0) check("a_out_bits", 128'(a_out_bits), 128'(aq[0]));
        check("d_in_ready",  128'(d_in_ready),  128'(e_dir));
        check("d_out_valid", 128'(d_out_valid), 128'(dq.size() != 0));
        if (dq.size() != 0) check("d_out_bits", 128'(d_out_bits), 128'(dq[0]));
        check("inflight", 128'(inflight), 128'(infl));
        check("err", 128'(err_unexpected_d), 128'(err));
        ai   = av && e_air;
        ao   = aor && (aq.size() != 0);
        di   = dv && e_dir;
        dout = dor && (dq.size() != 0);
        @(posedge clock);
        if (ao) void'(aq.pop_front());
        if (ai) aq.push_back(ab);
        if (dout) void'(dq.pop_front());
        if (di) dq.push_back(db);
        if (di && infl == 0) err = 1'b1;
        if (ai && !dout) infl++;
        else if (!ai && dout && infl > 0) infl--;
        live = 1'b1;
        @(negedge clock);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        tl_a_t b[4];
        tl_d_t d_seq[12];
        logic [95:0] ra;
        logic [63:0] rd;
        bit av, aor, dv, dor;

        za = '0;
        zd = '0;
        reset = 1'b1;
        drive_idle();
        model_clear();
        for (int i = 0; i < 4; i++) b[i] = mk_a(25'h0001000 + 25'(i * 4), 7'(5 + i), 32'hA000_0000 + 32'(i));
        for (int i = 0; i < 12; i++) d_seq[i] = mk_d(7'(i), 32'hD000_0000 + 32'(i * 3));

        // Single request passes through with one cycle of latency.
        hold_reset();
        step(0, za, 0, 0, zd, 0);
        step(1, b[0], 1, 0, zd, 0);
        check("r37_a_out_valid", 128'(a_out_valid), 128'(1));
        check("r37_a_out_bits", 128'(a_out_bits), 128'(mk_a(25'h0001000, 7'd5, 32'hA000_0000)));
        check("r37_inflight", 128'(inflight), 128'(1));
        step(0, za, 1, 0, zd, 0);

        // A FIFO fills at two beats, then drains in order.
        hold_reset();
        step(0, za, 0, 0, zd, 0);
        step(1, b[0], 0, 0, zd, 0);
        step(1, b[1], 0, 0, zd, 0);
        check("r38_full_ready", 128'(a_in_ready), 128'(0));
        step(1, b[2], 0, 0, zd, 0);
        check("r38_head0", 128'(a_out_bits), 128'(b[0]));
        step(0, za, 1, 0, zd, 0);
        check("r38_head1", 128'(a_out_bits), 128'(b[1]));
        step(0, za, 1, 0, zd, 0);
        check("r38_empty", 128'(a_out_valid), 128'(0));
        step(1, b[2], 1, 0, zd, 0);
        check("r38_head2", 128'(a_out_bits), 128'(b[2]));
        step(0, za, 1, 0, zd, 0);

        // Inflight limit blocks A until a response is delivered.
        hold_reset();
        step(0, za, 0, 0, zd, 0);
        for (int i = 0; i < 4; i++) step(1, b[i], 1, 0, zd, 0);
        check("r39_inflight4", 128'(inflight), 128'(4));
        check("r39_blocked", 128'(a_in_ready), 128'(0));
        step(0, za, 1, 1, d_seq[11], 1);
        step(0, za, 1, 0, zd, 1);
        check("r39_inflight3", 128'(inflight), 128'(3));
        check("r39_unblocked", 128'(a_in_ready), 128'(1));

        // D FIFO at occupancy one with push and pop every cycle across pointer wrap.
        step(0, za, 0, 1, d_seq[0], 0);
        for (int k = 0; k < 10; k++) begin
            check("r40_order", 128'(d_out_bits), 128'(d_seq[k]));
            step(0, za, 0, 1, d_seq[k + 1], 1);
        end
        check("r40_last", 128'(d_out_bits), 128'(d_seq[10]));
        check("r40_occ", 128'(d_out_valid), 128'(1));
        step(0, za, 0, 0, zd, 1);

        // Unexpected response flags a sticky error but is still buffered.
        hold_reset();
        step(0, za, 0, 0, zd, 0);
        step(0, za, 0, 1, d_seq[3], 0);
        check("r41_err", 128'(err_unexpected_d), 128'(1));
        check("r41_inflight", 128'(inflight), 128'(0));
        step(0, za, 0, 0, zd, 0);
        check("r41_err_held", 128'(err_unexpected_d), 128'(1));
        check("r41_buffered", 128'(d_out_bits), 128'(d_seq[3]));

        // Asynchronous reset with both FIFOs full discards everything.
        hold_reset();
        step(0, za, 0, 0, zd, 0);
        step(1, b[0], 0, 0, zd, 0);
        step(1, b[1], 0, 0, zd, 0);
        step(0, za, 0, 1, d_seq[0], 0);
        step(0, za, 0, 1, d_seq[1], 0);
        check("r42_a_full", 128'(a_in_ready), 128'(0));
        check("r42_d_full", 128'(d_in_ready), 128'(0));
        drive_idle();
        #2;
        reset = 1'b1;
        #1;
        check_quiet("r42_async");
        model_clear();
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) step(0, za, 1, 0, zd, 1);
        check("r42_no_stale_a", 128'(a_out_valid), 128'(0));
        check("r42_no_stale_d", 128'(d_out_valid), 128'(0));

        // Random traffic against the model.
        hold_reset();
        for (int n = 0; n < 3000; n++) begin
            ra  = {$urandom(), $urandom(), $urandom()};
            rd  = {$urandom(), $urandom()};
            av  = ($urandom_range(0, 2) != 0);
            aor = ($urandom_range(0, 3) != 0);
            dv  = ($urandom_range(0, 1) == 1) && (infl > 0 || $urandom_range(0, 63) == 0);
            dor = ($urandom_range(0, 3) != 0);
            step(av, ra[77:0], aor, dv, rd[48:0], dor);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/tl_ul_port_buffer.md
TL_UL_PORT_BUFFER -- requirements
Module: tl_ul_port_buffer

Interface
REQ-001 SHALL have parameter A_DEPTH, default 2: A-channel FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter D_DEPTH, default 2: D-channel FIFO entries (power of two, >=2).
REQ-003 SHALL have parameter MAX_INFLIGHT, default 4: maximum outstanding requests (1..15).
REQ-004 clock  input  1  sole clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 a_in_valid  input  1  upstream A request valid.
REQ-007 a_in_ready  output  1  buffer accepts A beat.
REQ-008 a_in_bits  input  78  tl_a_t: opcode[3], param[3], size[3], source[7], address[25], mask[4], data[32], corrupt[1].
REQ-009 a_out_valid  output  1  downstream A beat valid.
REQ-010 a_out_ready  input  1  downstream accepts A beat.
REQ-011 a_out_bits  output  78  tl_a_t, head of A FIFO.
REQ-012 d_in_valid  input  1  downstream D response valid.
REQ-013 d_in_ready  output  1  buffer accepts D beat.
REQ-014 d_in_bits  input  49  tl_d_t: opcode[3], param[2], size[3], source[7], data[32], denied[1], corrupt[1].
REQ-015 d_out_valid  output  1  upstream D beat valid.
REQ-016 d_out_ready  input  1  upstream accepts D beat.
REQ-017 d_out_bits  output  49  tl_d_t, head of D FIFO.
REQ-018 inflight  output  4  outstanding-request count.
REQ-019 err_unexpected_d  output  1  sticky: D accepted while inflight was 0.

Function
REQ-020 A fire (in) = a_in_valid & a_in_ready; same pattern for a_out, d_in, d_out.
REQ-021 a_in_ready SHALL be (A FIFO not full) & (inflight < MAX_INFLIGHT); combinational, never dependent on a_in_valid.
REQ-022 a_out_valid SHALL be A FIFO not empty; a_out_bits SHALL be the head entry and stable while valid & !ready.
REQ-023 d_in_ready SHALL be D FIFO not full; d_out_valid SHALL be D FIFO not empty, head stable while stalled.
REQ-024 Latency: a beat written at edge N SHALL be visible on the output after edge N (1 cycle); no combinational in-to-out bypass.
REQ-025 Both FIFOs SHALL preserve order; bits passed unmodified.
REQ-026 Full FIFO with simultaneous out-fire: in-ready stays low that cycle (no pass-through when full).
REQ-027 Empty FIFO: in and out never fire in the same cycle for one entry; occupancy +1.
REQ-028 Simultaneous push and pop on partially full FIFO: occupancy unchanged, pointers both advance, wrap modulo depth.
REQ-029 inflight SHALL increment on a_in fire, decrement on d_out fire, unchanged when both or neither; never exceeds MAX_INFLIGHT.
REQ-030 d_out fire at inflight 0 SHALL leave inflight at 0 (saturate).
REQ-031 d_in fire while inflight==0 SHALL set err_unexpected_d next cycle; cleared only by reset; beat still buffered.

Reset
REQ-032 On reset assertion, asynchronously: FIFO pointers/counts 0, inflight 0, err_unexpected_d 0.
REQ-033 During reset: a_in_ready, a_out_valid, d_in_ready, d_out_valid SHALL be 0; FIFO data storage not reset.
REQ-034 Reset mid-operation SHALL discard all buffered beats; first ready after deassertion is the next clock edge.

Structure
REQ-035 Package tl_ul_pkg SHALL hold tl_a_t, tl_d_t, field widths and TL opcode constants.
REQ-036 One sub-module, tl_ul_fifo (parameterised width/depth, count/ptr based), instantiated for A and D.

Verification
REQ-037 Reset, then A beat address 0x0001000, source 5, a_out_ready=1 -> a_out_valid one cycle later with identical bits; inflight=1.
REQ-038 a_out_ready=0, push 3 A beats -> a_in_ready drops after 2nd beat (A_DEPTH=2); release -> beats out in order.
REQ-039 Issue 4 A beats, no D -> a_in_ready=0 at inflight=4; one D delivered -> inflight=3, a_in_ready=1 next cycle.
REQ-040 D FIFO holding 1, simultaneous d_in and d_out fire for 10 cycles -> occupancy stays 1, data order preserved across wrap.
REQ-041 D beat with inflight=0 -> err_unexpected_d=1 next cycle and held; inflight stays 0.
REQ-042 Assert reset with both FIFOs full -> all valids 0 immediately, inflight=0, no stale beat emitted after release.
